// File: rtl/ship_draw.sv
// rtl/ship_draw.sv - 48x48 ROM sprite overlay on a VGA stream, two-clock pipeline.
// Optional macro SHIP_BLINK_EN: the sunk sprite blinks on a 64-frame cycle.
module ship_draw #(
  parameter logic [11:0] SHIP_COLOR  = 12'h8_8_8,
  parameter int          SPRITE_SIZE = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        sunk,
  output logic [7:0]  rom_addr,
  input  logic [47:0] rom_data,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  logic [10:0] r_x_sh, r_y_sh;
  logic        r_sunk_sh;
  logic        r_sh_valid;

  logic [10:0] r_hcount_0, r_vcount_0, r_hcount_1, r_vcount_1;
  logic        r_hsync_0, r_vsync_0, r_hblnk_0, r_vblnk_0;
  logic        r_hsync_1, r_vsync_1, r_hblnk_1, r_vblnk_1;
  logic [11:0] r_rgb_0, r_rgb_1;
  logic [5:0]  r_col_0, r_col_1;
  logic        r_in_sprite_0, r_in_sprite_1;
  logic [7:0]  r_rom_addr;

  logic        w_frame_start;
  logic [11:0] w_dx, w_dy;
  logic        w_in_x, w_in_y;
  logic        w_draw_en;
  logic [7:0]  w_addr;
  logic [5:0]  w_bit_idx;
  logic        w_pix;
  logic        w_blank;

  assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

  // Unsigned 12-bit differences: a pixel left of / above the corner wraps to a huge value.
  assign w_dx   = {1'b0, hcount_in} - {1'b0, r_x_sh};
  assign w_dy   = {1'b0, vcount_in} - {1'b0, r_y_sh};
  assign w_in_x = (w_dx < 12'(SPRITE_SIZE));
  assign w_in_y = (w_dy < 12'(SPRITE_SIZE));
  assign w_addr = w_dy[7:0] + (r_sunk_sh ? 8'(SPRITE_SIZE) : 8'd0);

`ifdef SHIP_BLINK_EN
  logic [5:0] r_frame_cnt;
  logic       r_hide_sh;
  assign w_draw_en = r_sh_valid & ~r_hide_sh;
`else
  assign w_draw_en = r_sh_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_sh        <= '0;
      r_y_sh        <= '0;
      r_sunk_sh     <= 1'b0;
      r_sh_valid    <= 1'b0;
      r_hcount_0    <= '0;
      r_vcount_0    <= '0;
      r_hsync_0     <= 1'b0;
      r_vsync_0     <= 1'b0;
      r_hblnk_0     <= 1'b0;
      r_vblnk_0     <= 1'b0;
      r_rgb_0       <= '0;
      r_col_0       <= '0;
      r_in_sprite_0 <= 1'b0;
      r_rom_addr    <= '0;
      r_hcount_1    <= '0;
      r_vcount_1    <= '0;
      r_hsync_1     <= 1'b0;
      r_vsync_1     <= 1'b0;
      r_hblnk_1     <= 1'b0;
      r_vblnk_1     <= 1'b0;
      r_rgb_1       <= '0;
      r_col_1       <= '0;
      r_in_sprite_1 <= 1'b0;
`ifdef SHIP_BLINK_EN
      r_frame_cnt   <= '0;
      r_hide_sh     <= 1'b0;
`endif
    end else begin
      if (w_frame_start) begin
        r_x_sh     <= xpos;
        r_y_sh     <= ypos;
        r_sunk_sh  <= sunk;
        r_sh_valid <= 1'b1;
`ifdef SHIP_BLINK_EN
        r_hide_sh   <= sunk & r_frame_cnt[5];
        r_frame_cnt <= r_frame_cnt + 6'd1;
`endif
      end

      r_hcount_0    <= hcount_in;
      r_vcount_0    <= vcount_in;
      r_hsync_0     <= hsync_in;
      r_vsync_0     <= vsync_in;
      r_hblnk_0     <= hblnk_in;
      r_vblnk_0     <= vblnk_in;
      r_rgb_0       <= rgb_in;
      r_col_0       <= w_dx[5:0];
      r_in_sprite_0 <= w_in_x & w_in_y & w_draw_en;
      r_rom_addr    <= w_in_y ? w_addr : 8'd0;

      // Second stage lines the pixel up with the ROM line fetched from r_rom_addr.
      r_hcount_1    <= r_hcount_0;
      r_vcount_1    <= r_vcount_0;
      r_hsync_1     <= r_hsync_0;
      r_vsync_1     <= r_vsync_0;
      r_hblnk_1     <= r_hblnk_0;
      r_vblnk_1     <= r_vblnk_0;
      r_rgb_1       <= r_rgb_0;
      r_col_1       <= r_col_0;
      r_in_sprite_1 <= r_in_sprite_0;
    end
  end

  // Leftmost sprite pixel is the ROM line MSB.
  assign w_bit_idx = 6'(SPRITE_SIZE - 1) - r_col_1;
  assign w_pix     = rom_data[w_bit_idx];
  assign w_blank   = r_hblnk_1 | r_vblnk_1;

  assign rom_addr   = r_rom_addr;
  assign hcount_out = r_hcount_1;
  assign vcount_out = r_vcount_1;
  assign hsync_out  = r_hsync_1;
  assign vsync_out  = r_vsync_1;
  assign hblnk_out  = r_hblnk_1;
  assign vblnk_out  = r_vblnk_1;
  assign rgb_out    = w_blank ? 12'h000 :
                      (r_in_sprite_1 && w_pix) ? SHIP_COLOR : r_rgb_1;

endmodule

// File: tb/tb_ship_draw.sv
// tb/tb_ship_draw.sv - randomized pixel stream against a frame-level sprite model.
module tb_ship_draw;

  localparam logic [11:0] COLOR = 12'h888;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in, xpos, ypos;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, sunk;
  logic [11:0] rgb_in;
  logic [7:0]  rom_addr;
  logic [47:0] rom_data;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  ship_draw #(.SHIP_COLOR(COLOR), .SPRITE_SIZE(48)) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .sunk(sunk),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  logic [47:0] rom [0:255];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic [7:0]  addr;
  } rec_t;

  rec_t hist0, hist1;
  int   total = 0;
  int   bad   = 0;
  bit   chk   = 1'b0;

  int       sx, sy;
  bit       ss, sv, hide;
  bit [5:0] fcnt;

  always @(posedge clk) begin
    #1;
    if (chk) begin
      total++;
      if (rom_addr !== hist0.addr) begin
        bad++;
        if (bad < 40) $display("FAIL rom_addr: got %0d expected %0d", rom_addr, hist0.addr);
      end
      total++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !==
          {hist1.h, hist1.v, hist1.hs, hist1.vs, hist1.hb, hist1.vb, hist1.rgb}) begin
        bad++;
        if (bad < 40)
          $display("FAIL stream: got h=%0d v=%0d sync=%b%b blnk=%b%b rgb=%h expected h=%0d v=%0d sync=%b%b blnk=%b%b rgb=%h",
                   hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
                   hist1.h, hist1.v, hist1.hs, hist1.vs, hist1.hb, hist1.vb, hist1.rgb);
      end
    end
  end

  task automatic drive(input bit rst, input int h, input int v, input logic [11:0] rgb);
    rec_t r;
    int   dx, dy, line;
    bit   inx, iny, draw;
    rst_n     = rst;
    hcount_in = h[10:0];
    vcount_in = v[10:0];
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    hblnk_in  = (h >= 640);
    vblnk_in  = (v >= 480);
    rgb_in    = rgb;
    r = '0;
    if (!rst) begin
      hist0 = '0;
      sx = 0; sy = 0; ss = 0; sv = 0; hide = 0; fcnt = '0;
    end else begin
      dx   = h - sx;
      dy   = v - sy;
      inx  = (dx >= 0) && (dx < 48);
      iny  = (dy >= 0) && (dy < 48);
      line = dy + (ss ? 48 : 0);
      draw = 1'b0;
      if (sv && !hide && inx && iny) draw = rom[line][47 - dx];
      r.h = h[10:0]; r.v = v[10:0];
      r.hs = hsync_in; r.vs = vsync_in; r.hb = hblnk_in; r.vb = vblnk_in;
      r.addr = iny ? line[7:0] : 8'd0;
      r.rgb  = (hblnk_in || vblnk_in) ? 12'h000 : (draw ? COLOR : rgb);
      if (h == 0 && v == 0) begin
`ifdef SHIP_BLINK_EN
        hide = sunk && fcnt[5];
        fcnt = fcnt + 6'd1;
`endif
        sx = xpos; sy = ypos; ss = sunk; sv = 1'b1;
      end
    end
    hist1 = hist0;
    hist0 = r;
    @(negedge clk);
  endtask

  task automatic flush();
    drive(1, 700, 600, 12'h000);
    drive(1, 700, 600, 12'h000);
  endtask

  task automatic frame_start();
    drive(1, 0, 0, 12'($urandom));
  endtask

  task automatic rand_win(input int n, input int h0, input int h1, input int v0, input int v1);
    int h, v;
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(h1, h0);
      v = $urandom_range(v1, v0);
      if (h == 0 && v == 0) h = 1;
      drive(1, h, v, 12'($urandom));
    end
  endtask

  task automatic pin(input int h, input int v, input logic [11:0] rgb, input logic [11:0] exp, input string nm);
    drive(1, h, v, rgb);
    drive(1, 700, 600, 12'h000);
    total++;
    if (rgb_out !== exp) begin
      bad++;
      $display("FAIL %s: rgb_out=%h expected %h", nm, rgb_out, exp);
    end
  endtask

  task automatic pin_addr(input int h, input int v, input logic [7:0] exp, input string nm);
    drive(1, h, v, 12'h0);
    total++;
    if (rom_addr !== exp) begin
      bad++;
      $display("FAIL %s: rom_addr=%0d expected %0d", nm, rom_addr, exp);
    end
  endtask

  task automatic set_intact_rom();
    for (int i = 0; i < 256; i++) rom[i] = (i < 48) ? {48{1'b1}} : ((i < 96) ? 48'h0 : {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
  endtask

  initial begin
    rst_n = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
    xpos = 11'd100; ypos = 11'd50; sunk = 1'b0;
    hist0 = '0; hist1 = '0;
    sx = 0; sy = 0; ss = 0; sv = 0; hide = 0; fcnt = '0;
    set_intact_rom();
    #1 rst_n = 1'b0;
    chk = 1'b1;
    @(negedge clk);

    // Reset held with random inputs, then pass-through until a frame start.
    for (int i = 0; i < 10; i++) drive(0, $urandom_range(800, 0), $urandom_range(525, 0), 12'($urandom));
    rand_win(30, 1, 60, 1, 60);
    pin(10, 10, 12'h5a5, 12'h5a5, "pre_latch_passthru");

    // Intact sprite at (100,50).
    frame_start();
    pin(100, 50, 12'h123, COLOR, "intact_top_left");
    pin(147, 97, 12'h123, COLOR, "intact_bottom_right");
    pin(148, 97, 12'h456, 12'h456, "intact_right_of");
    pin(99, 50, 12'h789, 12'h789, "intact_left_of");
    pin(100, 98, 12'habc, 12'habc, "intact_below");
    rand_win(1500, 80, 170, 30, 110);

    // Sunk sprite, all-zero image.
    sunk = 1'b1;
    frame_start();
    pin_addr(100, 50, 8'd48, "sunk_addr_first");
    pin_addr(120, 97, 8'd95, "sunk_addr_last");
    pin(110, 60, 12'h321, 12'h321, "sunk_zero_bg");
    rand_win(800, 80, 170, 30, 110);
    flush();
    for (int i = 48; i < 96; i++) rom[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    rand_win(1200, 80, 170, 30, 110);
    flush();
    set_intact_rom();

    // Mid-frame position change takes effect only at the next frame start.
    sunk = 1'b0;
    xpos = 11'd100;
    frame_start();
    rand_win(200, 80, 170, 30, 199);
    drive(1, 50, 200, 12'h0);
    xpos = 11'd300;
    pin(100, 60, 12'h111, COLOR, "midframe_old_pos");
    pin(300, 60, 12'h222, 12'h222, "midframe_new_hidden");
    rand_win(300, 80, 360, 30, 110);
    frame_start();
    pin(300, 60, 12'h333, COLOR, "nextframe_new_pos");
    pin(100, 60, 12'h444, 12'h444, "nextframe_old_gone");
    rand_win(300, 80, 360, 30, 110);

    // Edge clip at the bottom-right corner of 640x480.
    xpos = 11'd620; ypos = 11'd460;
    frame_start();
    pin(639, 479, 12'h555, COLOR, "clip_corner_in");
    pin(640, 479, 12'h555, 12'h000, "clip_hblank");
    pin(619, 460, 12'h666, 12'h666, "clip_left_of");
    pin(0, 5, 12'h777, 12'h777, "clip_no_wrap_x");
    pin(5, 0, 12'h999, 12'h999, "clip_no_wrap_y");
    rand_win(1000, 580, 799, 420, 524);
    rand_win(500, 0, 60, 0, 60);

    // Reset mid-line while drawing.
    rand_win(5, 620, 639, 460, 479);
    for (int i = 0; i < 3; i++) drive(0, 630, 470, 12'($urandom));
    pin(630, 470, 12'hbbb, 12'hbbb, "post_reset_no_overlay");
    frame_start();
    pin(630, 470, 12'hbbb, COLOR, "post_reset_relatched");

    // Random images, positions and mid-frame changes.
    flush();
    for (int i = 0; i < 256; i++) rom[i] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    for (int f = 0; f < 25; f++) begin
      xpos = 11'($urandom_range(700, 0));
      ypos = 11'($urandom_range(520, 0));
      sunk = 1'($urandom);
      frame_start();
      rand_win(60, (xpos > 10) ? xpos - 10 : 0, xpos + 60, (ypos > 10) ? ypos - 10 : 0, ypos + 60);
      xpos = 11'($urandom_range(700, 0));
      sunk = 1'($urandom);
      rand_win(60, (sx > 10) ? sx - 10 : 0, sx + 60, (sy > 10) ? sy - 10 : 0, sy + 60);
    end

`ifdef SHIP_BLINK_EN
    sunk = 1'b1; xpos = 11'd100; ypos = 11'd50;
    for (int f = 0; f < 66; f++) begin
      frame_start();
      rand_win(20, 100, 147, 50, 97);
    end
`endif

    flush();
    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ship_draw.md
SHIP_DRAW -- requirements
Module: ship_draw

Interface
REQ-001 Parameter SHIP_COLOR, default 12'h8_8_8: RGB444 colour for set sprite bits.
REQ-002 Parameter SPRITE_SIZE, default 48: sprite width and height in pixels; fixed at 48 because the ROM line is 48 bits.
REQ-003 clk  in  1: pixel clock; the only clock.
REQ-004 rst_n  in  1: reset, asynchronous and active-low.
REQ-005 hcount_in, vcount_in  in  11 each: VGA counters.
REQ-006 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each: VGA timing.
REQ-007 rgb_in  in  12: background pixel.
REQ-008 xpos, ypos  in  11 each: sprite top-left corner, sampled at frame start only.
REQ-009 sunk  in  1: selects sprite image; 0 = intact (ROM lines 0-47), 1 = sunk (ROM lines 48-95); sampled at frame start only.
REQ-010 rom_addr  out  8: ROM line address.
REQ-011 rom_data  in  48: ROM line, valid one clk after rom_addr.
REQ-012 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out: same widths as inputs; delayed and overlaid stream.

Function
REQ-013 Frame-start latch: when hcount_in==0 and vcount_in==0, xpos, ypos and sunk SHALL load into shadow registers; shadow values are used for the whole frame; mid-frame changes have no visible effect.
REQ-014 Stage 0 (registered): in_x = hcount_in - x_sh in 0..47; in_y = vcount_in - y_sh in 0..47; both differences use 12-bit unsigned arithmetic so negative results fall out of range; row = vcount_in - y_sh.
REQ-015 rom_addr SHALL be registered: rom_addr = row + 48*sunk_sh when in_y, else 8'd0.
REQ-016 Stage 0 SHALL also register col = hcount_in - x_sh (6 bits) and the flag in_sprite = in_x & in_y.
REQ-017 Stage 1 SHALL delay col and in_sprite one more clk to align with rom_data.
REQ-018 Output stage: if in_sprite_d, not blanking, and rom_data[47-col_d]==1, rgb_out = SHIP_COLOR; otherwise rgb_out = delayed rgb_in.
REQ-019 Latency: every *_out SHALL equal the corresponding input delayed exactly 2 clks, except rgb_out, which carries the overlay.
REQ-020 Sprite clipped at the right/bottom screen edge: pixels outside counter range are never drawn; no wrap-around to the left or top.
REQ-021 Outputs during blanking (hblnk or vblnk delayed) SHALL have rgb_out = 12'h000.

Reset
REQ-022 On rst_n low, all outputs and pipeline registers SHALL be 0 asynchronously; shadow x/y = 0 and sunk = 0.
REQ-023 After release, the first valid overlay SHALL appear only after the next frame-start latch; before that, rgb_out passes the delayed rgb_in.
REQ-024 Reset asserted mid-line SHALL clear the pipeline immediately; no stale overlay pixels after release.

Configuration
REQ-025 Macro SHIP_BLINK_EN: when defined, a 6-bit frame counter increments at each frame start, and a sunk sprite is drawn only while counter[5]==0, giving a 32-frame on / 32-frame off cycle. The counter resets to 0.
REQ-026 Without SHIP_BLINK_EN: no counter is present, and the sunk sprite is drawn every frame.

Verification
REQ-027 Reset: hold rst_n=0 with random inputs -> all outputs 0; release -> rgb_out = rgb_in delayed 2 clks until frame start.
REQ-028 Intact sprite: xpos=100, ypos=50, sunk=0, rom model returns all-ones for lines 0-47 -> rgb_out = 12'h888 exactly for hcount_out 100..147, vcount_out 50..97.
REQ-029 Sunk sprite: same position, sunk=1 -> rom_addr 48..95 observed; all-zero data -> rgb_out = background everywhere.
REQ-030 Mid-frame change: change xpos from 100 to 300 at vcount=200 -> current frame unchanged; next frame sprite at x=300.
REQ-031 Edge clip: xpos=620, ypos=460 on 640x480 -> only columns 620..639 and rows 460..479 are drawn; nothing is drawn at x=0 or y=0.
REQ-032 SHIP_BLINK_EN defined, sunk=1, bit pattern nonzero -> sprite visible in frames 0-31, absent in 32-63, visible again in 64.
